// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: divider-change controller with settle timing; define CLK_DIV_CTRL_CLAMP_EN to clamp zero requests to 1 and flag them on err_o
module clk_div_ctrl #(
    parameter int DIV_WIDTH   = 4,
    parameter int RESET_DIV   = 1,
    parameter int SETTLE_MULT = 2
) (
    input  logic                 clk_i,
    input  logic                 arst_ni,
    input  logic [DIV_WIDTH-1:0] req_div_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    output logic [DIV_WIDTH-1:0] div_o,
    output logic                 locked_o,
    output logic                 err_o
);
    // One spare bit so SETTLE_MULT*(2**DIV_WIDTH-1) never wraps
    localparam int CW = DIV_WIDTH + $clog2(SETTLE_MULT) + 1;
    localparam int RD1 = RESET_DIV > 0 ? RESET_DIV : 1;
    localparam logic [CW-1:0] CNT0 = CW'(SETTLE_MULT * RD1 - 1);
    localparam logic [CW-1:0] MULT = CW'(SETTLE_MULT);
    typedef enum logic {IDLE, SETTLE} state_t;
    state_t state;
    logic [CW-1:0] cnt, settle_m1;
    logic [DIV_WIDTH-1:0] req_eff, hi;
    always_comb begin
        hi = div_o > req_eff ? div_o : req_eff;
        settle_m1 = MULT * (hi == '0 ? CW'(1) : CW'(hi)) - CW'(1);
    end
    assign req_ready_o = state == IDLE;
    assign locked_o = state == IDLE;
`ifdef CLK_DIV_CTRL_CLAMP_EN
    assign req_eff = req_div_i == '0 ? DIV_WIDTH'(1) : req_div_i;
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) err_o <= 1'b0;
        else err_o <= state == IDLE && req_valid_i && req_div_i == '0;
    end
`else
    assign req_eff = req_div_i;
    assign err_o = 1'b0;
`endif
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state <= SETTLE;
            cnt <= CNT0;
            div_o <= DIV_WIDTH'(RESET_DIV);
        end else if (state == IDLE) begin
            if (req_valid_i && req_eff != div_o) begin
                state <= SETTLE;
                cnt <= settle_m1;
                div_o <= req_eff;
            end
        end else if (cnt == '0) begin
            state <= IDLE;
        end else begin
            cnt <= cnt - CW'(1);
        end
    end
endmodule
